// File: rtl/door_access_arbiter.sv
// Shares one door between entry/exit requesters, counts sensor-confirmed passages against CAP.
// Grant one cycle after request; all outputs registered; a grant closes on passage or timer expiry.
// Optional DOOR_TIMEOUT_EN builds a latching timeout ALARM state, cleared once both requests drop.
module door_access_arbiter #(
    parameter int CAP      = 15,
    parameter int OPEN_CYC = 50,
    parameter int OCC_W    = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ_IN,
    input  logic             REQ_OUT,
    input  logic             PASS,
    output logic             GNT_IN,
    output logic             GNT_OUT,
    output logic [OCC_W-1:0] OCC,
    output logic             FULL,
    output logic             EMPTY,
    output logic             BUSY,
    output logic             ALARM
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GIN,
        S_GOUT,
        S_CLOSE
`ifdef DOOR_TIMEOUT_EN
        , S_ALARM
`endif
    } state_t;

    localparam logic [OCC_W-1:0] CAP_V  = OCC_W'(CAP);
    localparam logic [7:0]       T_LOAD = 8'(OPEN_CYC - 1);

    state_t     state;
    logic [7:0] timer;
    logic       last_in;
    logic       pass_q;
    logic       pass_edge;
    logic       elig_in;
    logic       elig_out;

    assign pass_edge = PASS & ~pass_q;
    assign elig_in   = REQ_IN & ~FULL;
    assign elig_out  = REQ_OUT & ~EMPTY;

`ifndef DOOR_TIMEOUT_EN
    assign ALARM = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= S_IDLE;
            timer   <= '0;
            last_in <= 1'b0;
            // Starts high so a PASS level held through reset is not seen as an edge.
            pass_q  <= 1'b1;
            GNT_IN  <= 1'b0;
            GNT_OUT <= 1'b0;
            OCC     <= '0;
            FULL    <= 1'b0;
            EMPTY   <= 1'b1;
            BUSY    <= 1'b0;
`ifdef DOOR_TIMEOUT_EN
            ALARM   <= 1'b0;
`endif
        end else begin
            pass_q <= PASS;
            case (state)
                S_IDLE: begin
                    // On a tie, serve the direction opposite to the last one served.
                    if (elig_in && (!elig_out || !last_in)) begin
                        state   <= S_GIN;
                        last_in <= 1'b1;
                        timer   <= T_LOAD;
                        GNT_IN  <= 1'b1;
                        BUSY    <= 1'b1;
                    end else if (elig_out) begin
                        state   <= S_GOUT;
                        last_in <= 1'b0;
                        timer   <= T_LOAD;
                        GNT_OUT <= 1'b1;
                        BUSY    <= 1'b1;
                    end
                end
                S_GIN, S_GOUT: begin
                    if (pass_edge) begin
                        state   <= S_CLOSE;
                        GNT_IN  <= 1'b0;
                        GNT_OUT <= 1'b0;
                        if (state == S_GIN) begin
                            OCC   <= OCC + 1'b1;
                            FULL  <= (OCC == CAP_V - 1'b1);
                            EMPTY <= 1'b0;
                        end else begin
                            OCC   <= OCC - 1'b1;
                            FULL  <= 1'b0;
                            EMPTY <= (OCC == OCC_W'(1));
                        end
                    end else if (timer == '0) begin
                        GNT_IN  <= 1'b0;
                        GNT_OUT <= 1'b0;
`ifdef DOOR_TIMEOUT_EN
                        state   <= S_ALARM;
                        ALARM   <= 1'b1;
`else
                        state   <= S_CLOSE;
`endif
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_CLOSE: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                end
`ifdef DOOR_TIMEOUT_EN
                S_ALARM: begin
                    if (!REQ_IN && !REQ_OUT) begin
                        state <= S_IDLE;
                        ALARM <= 1'b0;
                        BUSY  <= 1'b0;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_door_access_arbiter.sv
// Table-driven bench for door_access_arbiter (CAP=3, OPEN_CYC=4, OCC_W=2).
module tb_door_access_arbiter;

    localparam int CAP      = 3;
    localparam int OPEN_CYC = 4;
    localparam int OCC_W    = 2;
`ifdef DOOR_TIMEOUT_EN
    localparam bit TA = 1'b1;
`else
    localparam bit TA = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RST;
    logic             REQ_IN, REQ_OUT, PASS;
    logic             GNT_IN, GNT_OUT, FULL, EMPTY, BUSY, ALARM;
    logic [OCC_W-1:0] OCC;

    door_access_arbiter #(.CAP(CAP), .OPEN_CYC(OPEN_CYC), .OCC_W(OCC_W)) dut (
        .CLK(CLK), .RST(RST), .REQ_IN(REQ_IN), .REQ_OUT(REQ_OUT), .PASS(PASS),
        .GNT_IN(GNT_IN), .GNT_OUT(GNT_OUT), .OCC(OCC), .FULL(FULL),
        .EMPTY(EMPTY), .BUSY(BUSY), .ALARM(ALARM)
    );

    always #5 CLK = ~CLK;

    // {GNT_IN, GNT_OUT, OCC, FULL, EMPTY, BUSY, ALARM}
    logic [7:0] obs;
    assign obs = {GNT_IN, GNT_OUT, OCC, FULL, EMPTY, BUSY, ALARM};
    localparam logic [7:0] RESET_VAL = 8'b0000_0100;

    typedef struct {
        string      name;
        logic       ri, ro, ps;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void add(string n, bit ri, bit ro, bit ps,
                                bit gi, bit go, int occ, bit bz, bit al);
        vec_t v;
        v.name = n;
        v.ri   = ri;
        v.ro   = ro;
        v.ps   = ps;
        v.exp  = {gi, go, 2'(occ), occ == CAP, occ == 0, bz, al};
        vecs.push_back(v);
    endfunction

    task automatic check(string n, logic [7:0] act, logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got gi/go/occ/full/empty/busy/alarm=%b, want %b", n, act, exp);
        end
    endtask

    // Expectations go to the scoreboard when inputs are driven, checked #1 after the edge.
    task automatic run_table();
        vec_t e;
        for (int i = 0; i < vecs.size(); i++) begin
            REQ_IN  = vecs[i].ri;
            REQ_OUT = vecs[i].ro;
            PASS    = vecs[i].ps;
            sb_q.push_back(vecs[i]);
            @(posedge CLK);
            #1;
            e = sb_q.pop_front();
            check(e.name, obs, e.exp);
        end
        vecs.delete();
    endtask

    initial begin
        RST = 1'b1; REQ_IN = 1'b0; REQ_OUT = 1'b0; PASS = 1'b1;
        @(posedge CLK); @(posedge CLK); #1;
        check("reset_hold", obs, RESET_VAL);
        RST = 1'b0;

        //  name  ri ro ps  gi go occ busy alarm
        add("R1", 0, 0, 1,  0, 0, 0, 0, 0);
        add("R2", 0, 0, 1,  0, 0, 0, 0, 0);
        add("A1", 1, 0, 0,  1, 0, 0, 1, 0);
        add("A2", 1, 0, 0,  1, 0, 0, 1, 0);
        add("A3", 1, 0, 1,  0, 0, 1, 1, 0);
        add("A4", 0, 0, 1,  0, 0, 1, 0, 0);
        add("A5", 0, 0, 0,  0, 0, 1, 0, 0);
        // exit grant that times out, with the request dropped mid-window
        add("B1", 0, 1, 0,  0, 1, 1, 1, 0);
        add("B2", 0, 0, 0,  0, 1, 1, 1, 0);
        add("B3", 0, 0, 0,  0, 1, 1, 1, 0);
        add("B4", 0, 0, 0,  0, 1, 1, 1, 0);
        add("B5", 0, 0, 0,  0, 0, 1, 1, TA);
        add("B6", 0, 0, 0,  0, 0, 1, 0, 0);
        // tie alternation IN, OUT, IN, OUT
        add("C1", 1, 1, 0,  1, 0, 1, 1, 0);
        add("C2", 1, 1, 1,  0, 0, 2, 1, 0);
        add("C3", 1, 1, 0,  0, 0, 2, 0, 0);
        add("C4", 1, 1, 0,  0, 1, 2, 1, 0);
        add("C5", 1, 1, 1,  0, 0, 1, 1, 0);
        add("C6", 1, 1, 0,  0, 0, 1, 0, 0);
        add("C7", 1, 1, 0,  1, 0, 1, 1, 0);
        add("C8", 1, 1, 1,  0, 0, 2, 1, 0);
        add("C9", 1, 1, 0,  0, 0, 2, 0, 0);
        add("C10", 1, 1, 0, 0, 1, 2, 1, 0);
        add("C11", 1, 1, 1, 0, 0, 1, 1, 0);
        add("C12", 0, 0, 0, 0, 0, 1, 0, 0);
        // fill to capacity, then entry is blocked
        add("D1", 1, 0, 0,  1, 0, 1, 1, 0);
        add("D2", 1, 0, 1,  0, 0, 2, 1, 0);
        add("D3", 1, 0, 0,  0, 0, 2, 0, 0);
        add("D4", 1, 0, 0,  1, 0, 2, 1, 0);
        add("D5", 1, 0, 1,  0, 0, 3, 1, 0);
        add("D6", 1, 0, 0,  0, 0, 3, 0, 0);
        for (int i = 0; i < 20; i++) add("D_full_blk", 1, 0, 0, 0, 0, 3, 0, 0);
        add("E1", 1, 1, 0,  0, 1, 3, 1, 0);
        add("E2", 1, 1, 1,  0, 0, 2, 1, 0);
        add("E3", 0, 0, 0,  0, 0, 2, 0, 0);
        add("E4", 0, 0, 1,  0, 0, 2, 0, 0);
        add("E5", 0, 0, 0,  0, 0, 2, 0, 0);
        run_table();

        // asynchronous reset in the middle of a grant
        add("M1", 1, 0, 0,  1, 0, 2, 1, 0);
        run_table();
        #3 RST = 1'b1;
        #1 check("reset_midgrant", obs, RESET_VAL);
        @(posedge CLK); #1;
        REQ_IN = 1'b0;
        RST = 1'b0;

        for (int i = 0; i < 10; i++) add("Z_empty_blk", 0, 1, 0, 0, 0, 0, 0, 0);
        // entry timeout with request held, then released
        add("T1", 1, 0, 0,  1, 0, 0, 1, 0);
        add("T2", 1, 0, 0,  1, 0, 0, 1, 0);
        add("T3", 1, 0, 0,  1, 0, 0, 1, 0);
        add("T4", 1, 0, 0,  1, 0, 0, 1, 0);
        add("T5", 1, 0, 0,  0, 0, 0, 1, TA);
        add("T6", 1, 0, 0,  0, 0, 0, TA, TA);
        add("T7", 0, 0, 0,  0, 0, 0, 0, 0);
        add("T8", 0, 0, 1,  0, 0, 0, 0, 0);
        add("T9", 0, 0, 0,  0, 0, 0, 0, 0);
        // passage in the same cycle as timer expiry wins
        add("G1", 1, 0, 0,  1, 0, 0, 1, 0);
        add("G2", 0, 0, 0,  1, 0, 0, 1, 0);
        add("G3", 0, 0, 0,  1, 0, 0, 1, 0);
        add("G4", 0, 0, 0,  1, 0, 0, 1, 0);
        add("G5", 0, 0, 1,  0, 0, 1, 1, 0);
        add("G6", 0, 0, 0,  0, 0, 1, 0, 0);
        run_table();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/door_access_arbiter.md
# door_access_arbiter

Arbitration and sequencing controller for the single-leaf access door. It shares the door between an entry requester and an exit requester, grants one direction at a time, and counts passages confirmed by the door sensor. It maintains room occupancy against a capacity limit and closes each grant on passage or timeout. It sits between the request switches/sensor and the door-state/indicator logic; the grant outputs drive the open-direction display and lights.

## Interface
- CAP, 15, maximum occupancy; an entry grant is never issued while OCC == CAP
- OPEN_CYC, 50, grant window length in CLK cycles; legal range 2..255
- OCC_W, 4, occupancy counter width; must satisfy 2^OCC_W > CAP
- CLK  in  1  system clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- REQ_IN  in  1  entry request, level
- REQ_OUT  in  1  exit request, level
- PASS  in  1  passage sensor; only a rising edge counts
- GNT_IN  out  1  entry direction granted (door open inward)
- GNT_OUT  out  1  exit direction granted (door open outward)
- OCC  out  OCC_W  current occupancy
- FULL  out  1  OCC == CAP
- EMPTY  out  1  OCC == 0
- BUSY  out  1  state != IDLE
- ALARM  out  1  timeout alarm; tied 0 unless DOOR_TIMEOUT_EN is defined

## Operation
- Eligibility:
  - elig_in = REQ_IN & !FULL
  - elig_out = REQ_OUT & !EMPTY
- LAST register holds the last-served direction. It resets to OUT, so IN wins the first tie.
- States: IDLE, GRANT_IN, GRANT_OUT, CLOSE, ALARM. The ALARM state exists only with DOOR_TIMEOUT_EN.
- IDLE:
  - only one eligible requester → grant that direction
  - both eligible → grant the direction opposite to LAST
  - neither eligible → stay in IDLE
  - on entry to a GRANT state: update LAST, load timer with OPEN_CYC-1
- GRANT_x:
  - the GNT_x output is high
  - the timer decrements every cycle
- Passage edge (pass_edge = PASS & !pass_q, where pass_q is PASS registered):
  - OCC increments for GRANT_IN, decrements for GRANT_OUT
  - next state is CLOSE
- Timer == 0 with no pass_edge → timeout, OCC unchanged:
  - without DOOR_TIMEOUT_EN → next state CLOSE
  - with DOOR_TIMEOUT_EN → next state ALARM
- Same cycle as timer == 0 with pass_edge → passage wins; the count is applied.
- CLOSE: lasts one cycle, both grants low, then IDLE. A requester still holding its request is re-arbitrated normally in IDLE.
- ALARM:
  - grants low, ALARM high
  - leaves for IDLE only after a cycle in which REQ_IN == 0 and REQ_OUT == 0
- pass_edge in IDLE or CLOSE is ignored; OCC is unchanged.
- OCC cannot overflow or underflow, because eligibility gates both boundaries.
- A request dropped during GRANT does not shorten the window. The grant ends only on passage or timeout.

## Timing
- Reset values: GNT_IN=0, GNT_OUT=0, OCC=0, FULL=0, EMPTY=1, BUSY=0, ALARM=0, state=IDLE, LAST=OUT, pass_q=1.
  - pass_q=1 means a PASS level held high through reset release is not counted.
- All outputs are registered or decoded from registers; there are no combinational input-to-output paths.
- Request latency: REQ sampled high at edge t → GNT high after edge t (visible in cycle t+1).
- Passage: pass_edge sampled at edge p → after p, GNT low, OCC/FULL/EMPTY updated, state CLOSE; IDLE after p+1.
- Timeout: GNT stays high for exactly OPEN_CYC cycles.
- Minimum spacing between grants:
  - grant-to-grant: 3 cycles (GRANT ≥1, CLOSE 1, IDLE 1)
  - tie alternation: IN, OUT, IN, …
- RST asserted mid-grant → all state cleared immediately, asynchronously, to the reset values; no count is applied.

## Configuration
- DOOR_TIMEOUT_EN
  - Defined:
    - the ALARM state and ALARM output are built
    - a timeout latches ALARM until both requests are released
  - Undefined:
    - a timeout silently closes the grant via CLOSE
    - ALARM is a constant 0
    - the ALARM state is not synthesized

## Test plan
Bench parameters: CAP=3, OPEN_CYC=4.

- Reset with PASS held high, then release → all outputs at reset values; OCC stays 0 after release with no PASS toggle.
- Hold REQ_IN at edge 1, PASS rising at edge 3 → GNT_IN high in cycles 2–3, low from cycle 4; OCC=1, EMPTY=0 after edge 3; BUSY low by cycle 5.
- OCC=1, REQ_IN and REQ_OUT both held, PASS pulsed during each grant → grant order IN, OUT, IN, OUT; OCC sequence 2, 1, 2, 1.
- Three entries bring OCC to 3 → FULL=1; REQ_IN held for 20 cycles → GNT_IN never asserts; then REQ_OUT plus PASS → GNT_OUT, OCC=2, FULL=0.
- OCC=0, REQ_OUT held 10 cycles → no grant, BUSY=0.
- REQ_IN with no PASS:
  - without macro → GNT_IN high exactly 4 cycles, OCC unchanged, ALARM=0
  - with DOOR_TIMEOUT_EN → ALARM=1 until REQ_IN is dropped, then IDLE one cycle later
